wb_sram_ctrl: RTL
=================

WB_SRAM_CTRL -- requirements
Module: wb_sram_ctrl

Interface
REQ-001 SHALL have parameter RD_WAIT, default 2, number of cycles sram_oe_o is held before read data capture (min 1).
REQ-002 SHALL have parameter WR_WAIT, default 2, number of cycles sram_we_o is held high per write (min 1).
REQ-003 SHALL have one clock and an asynchronous active-high reset: clk_50mhz  in  1  system clock, all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 wb_cyc_i  in  1  Wishbone cycle valid.
REQ-006 wb_stb_i  in  1  Wishbone strobe.
REQ-007 wb_we_i  in  1  1 = write, 0 = read.
REQ-008 wb_adr_i  in  20  byte address; sram_addr_o = wb_adr_i[19:2].
REQ-009 wb_sel_i  in  4  byte lanes; bit3 = [31:24] ... bit0 = [7:0].
REQ-010 wb_dat_i  in  32  write data.
REQ-011 wb_dat_o  out  32  registered read data.
REQ-012 wb_ack_o  out  1  single-cycle transfer acknowledge.
REQ-013 sram_dat_i  in  32  {SRAM1, SRAM0} read data from pads.
REQ-014 sram_dat_o  out  32  write data to pads; pad drivers enable per lane on sram_we_o & sram_bsel_o.
REQ-015 sram_addr_o  out  18  32-bit word address.
REQ-016 sram_bsel_o  out  4  byte-lane select.
REQ-017 sram_cs_o, sram_oe_o, sram_we_o  out  1 each  active-high chip select, output enable, write enable.

Function
REQ-018 All sram_* and wb_* outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-019 FSM states SHALL be IDLE, RD, WSETUP, WPULSE, WHOLD, ACK.
REQ-020 IDLE: on wb_cyc_i & wb_stb_i at edge E0, latch wb_adr_i, wb_sel_i, wb_dat_i, wb_we_i; sel==0 -> ACK; we=0 -> RD; we=1 -> WSETUP.
REQ-021 RD: cs=1, oe=1, we=0 for RD_WAIT cycles; wb_dat_o <= sram_dat_i on last RD cycle; then ACK.
REQ-022 Read: wb_ack_o high exactly in cycle starting at E0+RD_WAIT+1.
REQ-023 WSETUP: cs=1, oe=0, we=0, address/bsel/data stable, 1 cycle.
REQ-024 WPULSE: cs=1, we=1 for WR_WAIT cycles.
REQ-025 WHOLD: cs=1, we=0, address/bsel unchanged, 1 cycle; then ACK.
REQ-026 Write: wb_ack_o high exactly in cycle starting at E0+WR_WAIT+3.
REQ-027 ACK: cs=oe=we=0, wb_ack_o=1 for one cycle if wb_cyc_i still high, else 0; then IDLE; no request sampled in ACK.
REQ-028 sram_oe_o and sram_we_o SHALL never be high in the same cycle.
REQ-029 sram_addr_o, sram_bsel_o, sram_dat_o SHALL be constant while sram_cs_o is high.
REQ-030 wb_cyc_i dropping mid-transfer SHALL NOT shorten the SRAM access; ack suppressed per REQ-027.
REQ-031 wb_sel_i==0: no SRAM strobe (cs stays 0), ack at E0+1.
REQ-032 Back-to-back: new request accepted no earlier than the edge after ACK; cs low at least one cycle between accesses.
REQ-033 wb_dat_o SHALL hold the last read value until next read capture.

Reset
REQ-034 Reset asserted: state IDLE, all outputs 0 (sram_cs_o=oe=we=0, ack=0, addr/bsel/dat_o=0) immediately, regardless of clock.
REQ-035 Reset mid-write SHALL drop sram_we_o asynchronously; aborted transfer is never acknowledged.

Structure
REQ-036 FSM state encodings and SRAM_AW=18 SHALL live in the shared project package/include.
REQ-037 Single module; one wait-state down-counter inside, no sub-module.

Verification
REQ-038 Read adr=0x00104, sel=1111, SRAM model returns 0xDEADBEEF -> sram_addr_o=0x00041, oe high 2 cycles, ack at E0+3, wb_dat_o=0xDEADBEEF.
REQ-039 Write adr=0x00008, sel=0100, dat=0x00AB0000 -> cs 4 cycles, we high 2 cycles not first/last, bsel=0100, ack at E0+5; model lane2=0xAB, others untouched.
REQ-040 Write then immediate read same address, RD_WAIT=1, WR_WAIT=3 -> cs gap >=1 cycle, read returns written value, ack timings E0+6 and E0'+2.
REQ-041 sel=0000 write -> no cs/we activity, ack at E0+1.
REQ-042 wb_cyc_i dropped during WPULSE -> write completes in model, no ack; reset asserted during WPULSE -> sram_we_o low same instant, no ack.
REQ-043 Random 1000 mixed transfers vs reference memory -> data matches, oe&we never both high, addr/bsel stable under cs.

Source files
------------

// File: rtl/wb_sram_ctrl_pkg.sv
// Shared types and sizes for the Wishbone-to-SRAM controller.
// Holds FSM encodings and bus/SRAM widths used by the interface and core.
package wb_sram_ctrl_pkg;

    localparam int SRAM_AW = 18;
    localparam int WB_AW   = 20;
    localparam int DW      = 32;
    localparam int SW      = 4;
    localparam int CNT_W   = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WSETUP = 3'd2,
        WPULSE = 3'd3,
        WHOLD  = 3'd4,
        ACK    = 3'd5
    } state_t;

endpackage

// File: rtl/wb_sram_ctrl_if.sv
// Wishbone slave port plus SRAM pad port of the controller.
// The controller takes the slave view, the bus owner takes master.
interface wb_sram_ctrl_if;
    import wb_sram_ctrl_pkg::*;

    logic               wb_cyc_i;
    logic               wb_stb_i;
    logic               wb_we_i;
    logic [WB_AW-1:0]   wb_adr_i;
    logic [SW-1:0]      wb_sel_i;
    logic [DW-1:0]      wb_dat_i;
    logic [DW-1:0]      wb_dat_o;
    logic               wb_ack_o;

    logic [DW-1:0]      sram_dat_i;
    logic [DW-1:0]      sram_dat_o;
    logic [SRAM_AW-1:0] sram_addr_o;
    logic [SW-1:0]      sram_bsel_o;
    logic               sram_cs_o;
    logic               sram_oe_o;
    logic               sram_we_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i,
        input  wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o,
        input  sram_dat_i,
        output sram_dat_o, sram_addr_o, sram_bsel_o,
        output sram_cs_o, sram_oe_o, sram_we_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i,
        output wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o,
        output sram_dat_i,
        input  sram_dat_o, sram_addr_o, sram_bsel_o,
        input  sram_cs_o, sram_oe_o, sram_we_o
    );

endinterface

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave driving an asynchronous 32-bit SRAM.
// All strobes registered; writes use setup / pulse / hold phases.
module wb_sram_ctrl
    import wb_sram_ctrl_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic          clk_50mhz,
    input  logic          reset,
    wb_sram_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic             armed;
    logic             wr_q;
    logic [CNT_W-1:0] cnt;

    logic unused_adr;
    assign unused_adr = ^bus.wb_adr_i[1:0];

    // The request is latched onto the pads one cycle before cs rises,
    // so address, lanes and data are settled for the whole access.
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            armed           <= 1'b0;
            wr_q            <= 1'b0;
            cnt             <= '0;
            bus.wb_ack_o    <= 1'b0;
            bus.wb_dat_o    <= '0;
            bus.sram_addr_o <= '0;
            bus.sram_bsel_o <= '0;
            bus.sram_dat_o  <= '0;
            bus.sram_cs_o   <= 1'b0;
            bus.sram_oe_o   <= 1'b0;
            bus.sram_we_o   <= 1'b0;
        end else begin
            bus.wb_ack_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (armed) begin
                        armed <= 1'b0;
                        if (bus.sram_bsel_o == '0) begin
                            state        <= ACK;
                            bus.wb_ack_o <= bus.wb_cyc_i;
                        end else if (wr_q) begin
                            state         <= WSETUP;
                            bus.sram_cs_o <= 1'b1;
                        end else begin
                            state         <= RD;
                            bus.sram_cs_o <= 1'b1;
                            bus.sram_oe_o <= 1'b1;
                            cnt           <= RD_LOAD;
                        end
                    end else if (bus.wb_cyc_i && bus.wb_stb_i) begin
                        armed           <= 1'b1;
                        wr_q            <= bus.wb_we_i;
                        bus.sram_addr_o <= bus.wb_adr_i[WB_AW-1:2];
                        bus.sram_bsel_o <= bus.wb_sel_i;
                        bus.sram_dat_o  <= bus.wb_dat_i;
                    end
                end
                RD: begin
                    if (cnt == '0) begin
                        state         <= ACK;
                        bus.wb_dat_o  <= bus.sram_dat_i;
                        bus.wb_ack_o  <= bus.wb_cyc_i;
                        bus.sram_cs_o <= 1'b0;
                        bus.sram_oe_o <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WSETUP: begin
                    state         <= WPULSE;
                    bus.sram_we_o <= 1'b1;
                    cnt           <= WR_LOAD;
                end
                WPULSE: begin
                    if (cnt == '0) begin
                        state         <= WHOLD;
                        bus.sram_we_o <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WHOLD: begin
                    // A dropped cycle still completes; only the ack is withheld.
                    state         <= ACK;
                    bus.wb_ack_o  <= bus.wb_cyc_i;
                    bus.sram_cs_o <= 1'b0;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
